switch_debounce: RTL and testbench

Per-channel synchronizer and debouncer for the board's slide switches, sitting directly upstream of the switch-to-LED stage. It takes raw asynchronous switch levels, brings them into the `clk` domain, and presents a level only after it has been stable for a programmable number of cycles. It can also emit single-cycle rise and fall pulses for downstream logic.

---
 rtl/switch_debounce.sv | 70 +++++++
 tb/tb_switch_debounce.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// Per-channel two-flop synchronizer and stability-count debouncer for slide switches.
// Optional registered rise/fall pulses are built when SWITCH_DEBOUNCE_EDGE_EN is defined.
module switch_debounce #(
  parameter int N_SW            = 4,
  parameter int CNT_W           = 20,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_in,
  output logic [N_SW-1:0] sw_out
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  ,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall
`endif
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_SW-1:0]  sync1;
  logic [N_SW-1:0]  sync2;
  logic [N_SW-1:0]  mismatch;
  logic [N_SW-1:0]  commit;
  logic [CNT_W-1:0] cnt [N_SW];

  always_comb begin
    mismatch = sync2 ^ sw_out;
    commit   = '0;
    for (int unsigned i = 0; i < N_SW; i++) begin
      commit[i] = mismatch[i] && (cnt[i] == LAST);
    end
  end

  // A commit only happens on a mismatch, so toggling sw_out loads the synchronized level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      sw_out <= '0;
      for (int unsigned i = 0; i < N_SW; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1  <= sw_in;
      sync2  <= sync1;
      sw_out <= sw_out ^ commit;
      for (int unsigned i = 0; i < N_SW; i++) begin
        if (!mismatch[i] || commit[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_rise <= '0;
      sw_fall <= '0;
    end else begin
      sw_rise <= commit & sync2;
      sw_fall <= commit & ~sync2;
    end
  end
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Randomized bench for switch_debounce against a sliding-window reference model,
// plus directed reset, press, glitch and reset-mid-count scenarios.
module tb_switch_debounce;

  localparam int N   = 4;
  localparam int D   = 4;
  localparam int CW  = 3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] sw_in;
  logic [N-1:0] sw_out;
  logic [N-1:0] sw_rise;
  logic [N-1:0] sw_fall;

  int checks = 0;
  int errors = 0;

  switch_debounce #(
    .N_SW            (N),
    .CNT_W           (CW),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_in  (sw_in),
    .sw_out (sw_out)
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    ,
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
`endif
  );

`ifndef SWITCH_DEBOUNCE_EDGE_EN
  assign sw_rise = '0;
  assign sw_fall = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: level seen at sync2 is sw_in two edges late; a channel commits
  // when the last D pre-edge sync2 samples all disagree with the output.
  logic [N-1:0] m_s1, m_s2, m_out, m_rise, m_fall;
  logic [N-1:0] win [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
    win.delete();
  endtask

  task automatic model_edge();
    logic [N-1:0] commit;
    bit all_diff;
    if (!rst_n) return;
    win.push_back(m_s2);
    if (win.size() > D) void'(win.pop_front());
    commit = '0;
    for (int c = 0; c < N; c++) begin
      all_diff = (win.size() == D);
      foreach (win[k]) if (win[k][c] == m_out[c]) all_diff = 0;
      commit[c] = all_diff;
    end
    m_rise = commit & ~m_out;
    m_fall = commit & m_out;
    m_out  = m_out ^ commit;
    m_s2 = m_s1;
    m_s1 = sw_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("sw_out", 32'(sw_out), 32'(m_out));
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    check("sw_rise", 32'(sw_rise), 32'(m_rise));
    check("sw_fall", 32'(sw_fall), 32'(m_fall));
`endif
  endtask

  int rem [N];

  initial begin
    rst_n = 1'b0;
    sw_in = 4'hF;
    model_reset();

    // Reset held with all switches high: nothing propagates.
    repeat (3) begin
      tick();
      check("rst_hold_out", 32'(sw_out), 32'h0);
      check("rst_hold_rise", 32'(sw_rise), 32'h0);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("rst_rel_early", 32'(sw_out), 32'h0);
    end
    tick();
    check("rst_rel_6th", 32'(sw_out), 32'hF);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    check("rst_rel_rise", 32'(sw_rise), 32'hF);
`endif
    tick();
    check("rst_rel_rise_gone", 32'(sw_rise), 32'h0);

    // Settle everything low, then a clean press on channel 0.
    sw_in = '0;
    repeat (10) tick();
    check("settled_low", 32'(sw_out), 32'h0);
    sw_in = 4'h1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("press_early", 32'(sw_out[0]), 32'h0);
    end
    tick();
    check("press_6th", 32'(sw_out[0]), 32'h1);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    check("press_rise", 32'(sw_rise[0]), 32'h1);
`endif

    // Glitch of D-1 cycles on channel 2 while it is high.
    sw_in = 4'h5;
    repeat (8) tick();
    check("glitch_pre", 32'(sw_out[2]), 32'h1);
    sw_in = 4'h1;
    repeat (3) tick();
    sw_in = 4'h5;
    repeat (8) begin
      tick();
      check("glitch_hold", 32'(sw_out[2]), 32'h1);
      check("glitch_nofall", 32'(sw_fall[2]), 32'h0);
    end

    // Reset mid-count on channel 0.
    sw_in = 4'h0;
    repeat (8) tick();
    sw_in = 4'h1;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_out", 32'(sw_out), 32'h0);
    check("midrst_rise", 32'(sw_rise | sw_fall), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("midrst_early", 32'(sw_out[0]), 32'h0);
    end
    tick();
    check("midrst_6th", 32'(sw_out[0]), 32'h1);

    // Randomized per-channel hold lengths spanning glitches and commits.
    for (int c = 0; c < N; c++) rem[c] = $urandom_range(1, 7);
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      for (int c = 0; c < N; c++) begin
        rem[c]--;
        if (rem[c] == 0) begin
          sw_in[c] = ~sw_in[c];
          rem[c]   = $urandom_range(1, 7);
        end
      end
      if (cyc == 300) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rand_rst_out", 32'(sw_out), 32'h0);
        tick();
        rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
